// File: rtl/dut_alu_pipe.sv
// dut_alu_pipe: pipelined two-operand ALU with valid/ready handshakes on both sides.
// The ops are ADD, SUB, MAX unsigned and MIN unsigned.
// Stage 0 captures the combinational result. Stages 1..STAGES_p-1 only forward it.
// Outputs come straight from the last stage's registers.
// Optional feature: define ALU_PIPE_SAT_EN to saturate ADD/SUB (unsigned).
//   carry/ovf still report the unsaturated condition.
module dut_alu_pipe #(
   parameter int unsigned WIDTH_p  = 8,
   parameter int unsigned STAGES_p = 2,
   parameter int unsigned CNT_W_p  = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         op,
   input  logic [WIDTH_p-1:0] inA,
   input  logic [WIDTH_p-1:0] inB,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH_p-1:0] out,
   output logic               carry,
   output logic               ovf,
   output logic [CNT_W_p-1:0] txn_cnt
);

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MAX = 2'b10,
      OP_MIN = 2'b11
   } op_e;

   logic [WIDTH_p:0]   sum_w;
   logic [WIDTH_p:0]   dif_w;
   logic [WIDTH_p-1:0] res0;
   logic               cy0;
   logic               ov0;

   logic [STAGES_p-1:0] v_q;
   logic [STAGES_p-1:0] c_q;
   logic [STAGES_p-1:0] o_q;
   logic [STAGES_p-1:0] ld;
   logic [WIDTH_p-1:0]  d_q [STAGES_p];

   // Stage-0 arithmetic at WIDTH_p+1 bits; the top bit carries carry-out or borrow.
   always_comb begin
      sum_w = {1'b0, inA} + {1'b0, inB};
      dif_w = {1'b0, inA} - {1'b0, inB};
      res0  = '0;
      cy0   = 1'b0;
      ov0   = 1'b0;
      unique case (op_e'(op))
         OP_ADD: begin
            res0 = sum_w[WIDTH_p-1:0];
            cy0  = sum_w[WIDTH_p];
            ov0  = (inA[WIDTH_p-1] == inB[WIDTH_p-1]) &&
                   (sum_w[WIDTH_p-1] != inA[WIDTH_p-1]);
`ifdef ALU_PIPE_SAT_EN
            if (sum_w[WIDTH_p]) res0 = '1;
`endif
         end
         OP_SUB: begin
            res0 = dif_w[WIDTH_p-1:0];
            cy0  = dif_w[WIDTH_p];
            ov0  = (inA[WIDTH_p-1] != inB[WIDTH_p-1]) &&
                   (dif_w[WIDTH_p-1] != inA[WIDTH_p-1]);
`ifdef ALU_PIPE_SAT_EN
            if (dif_w[WIDTH_p]) res0 = '0;
`endif
         end
         OP_MAX: res0 = (inA > inB) ? inA : inB;
         OP_MIN: res0 = (inA < inB) ? inA : inB;
         default: res0 = '0;
      endcase
   end

   // Load enables from the last stage backward.
   // A stage loads when it is empty or when its contents move on this cycle.
   // The running chain variable avoids a self-referencing vector.
   always_comb begin
      logic chain;
      chain = out_ready;
      ld    = '0;
      for (int unsigned i = 0; i < STAGES_p; i++) begin
         chain                = !v_q[STAGES_p-1-i] || chain;
         ld[STAGES_p-1-i]     = chain;
      end
   end

   // Elastic pipeline registers. Data is captured only alongside a valid beat.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v_q <= '0;
         c_q <= '0;
         o_q <= '0;
         for (int unsigned i = 0; i < STAGES_p; i++) begin
            d_q[i] <= '0;
         end
      end else begin
         if (ld[0]) begin
            v_q[0] <= in_valid;
            if (in_valid) begin
               d_q[0] <= res0;
               c_q[0] <= cy0;
               o_q[0] <= ov0;
            end
         end
         for (int unsigned i = 1; i < STAGES_p; i++) begin
            if (ld[i]) begin
               v_q[i] <= v_q[i-1];
               if (v_q[i-1]) begin
                  d_q[i] <= d_q[i-1];
                  c_q[i] <= c_q[i-1];
                  o_q[i] <= o_q[i-1];
               end
            end
         end
      end
   end

   // Count of results delivered downstream; wraps naturally.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         txn_cnt <= '0;
      end else if (out_valid && out_ready) begin
         txn_cnt <= txn_cnt + 1'b1;
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = v_q[STAGES_p-1];
   assign out       = d_q[STAGES_p-1];
   assign carry     = c_q[STAGES_p-1];
   assign ovf       = o_q[STAGES_p-1];

endmodule

// File: tb/tb_dut_alu_pipe.sv
// tb_dut_alu_pipe: scoreboard bench for dut_alu_pipe.
// The stimulus side pushes expected results from a plain-arithmetic model.
// A negedge monitor checks handshakes, latency, stall hold and txn_cnt.
// Honours ALU_PIPE_SAT_EN in the reference model.
module tb_dut_alu_pipe;
   localparam int W  = 8;
   localparam int S  = 2;
   localparam int CW = 8;

   typedef struct {
      logic [W-1:0] r;
      logic         c;
      logic         v;
      int           t;
   } exp_t;

   logic          clk = 1'b0;
   logic          rstn;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    op;
   logic [W-1:0]  inA, inB;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out;
   logic          carry, ovf;
   logic [CW-1:0] txn_cnt;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   txn_model = 0;
   int   rdy_mode = 0;

   dut_alu_pipe #(.WIDTH_p(W), .STAGES_p(S), .CNT_W_p(CW)) u_dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .inA(inA), .inB(inB), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .carry(carry), .ovf(ovf), .txn_cnt(txn_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: unsigned wrap, carry/borrow and signed range from plain integer arithmetic.
   function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output logic v);
      longint m, ai, bi, as, bs, s;
      m  = longint'(1) << W;
      ai = longint'(a);
      bi = longint'(b);
      as = (ai >= m/2) ? ai - m : ai;
      bs = (bi >= m/2) ? bi - m : bi;
      c  = 1'b0;
      v  = 1'b0;
      r  = '0;
      case (o)
         2'd0: begin
            s = ai + bi;
            r = W'(s);
            c = (s >= m);
            v = (as + bs < -(m/2)) || (as + bs > m/2 - 1);
`ifdef ALU_PIPE_SAT_EN
            if (c) r = W'(m - 1);
`endif
         end
         2'd1: begin
            s = ai - bi;
            r = W'(s);
            c = (ai < bi);
            v = (as - bs < -(m/2)) || (as - bs > m/2 - 1);
`ifdef ALU_PIPE_SAT_EN
            if (c) r = '0;
`endif
         end
         2'd2: r = (ai > bi) ? a : b;
         default: r = (ai < bi) ? a : b;
      endcase
   endfunction

   // Downstream ready generator: 0 = always ready, 1 = random, 2 = stalled.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: compares the DUT against the queue head on every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rstn) begin
            logic ev;
            ev = (q.size() > 0) && (cyc >= q[0].t + S);
            chk("in_ready", in_ready, ((q.size() < S) || out_ready) ? 1 : 0);
            chk("out_valid", out_valid, ev ? 1 : 0);
            chk("txn_cnt", txn_cnt, txn_model % (1 << CW));
            if (out_valid && ev) begin
               chk("out", out, q[0].r);
               chk("carry", carry, q[0].c);
               chk("ovf", ovf, q[0].v);
               if (out_ready) begin
                  void'(q.pop_front());
                  txn_model++;
               end
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic drive_beat(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   n;
      n = 0;
      op = o; inA = a; inB = b; in_valid = 1'b1;
      ref_op(o, a, b, e.r, e.c, e.v);
      forever begin
         #5;
         if (in_ready) begin
            e.t = cyc;
            q.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
            break;
         end
         n++;
         if (n > 100) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready stuck 0 want 1");
            @(posedge clk); #1;
            in_valid = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (q.size() > 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: pending %0d want 0", q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic reset_check(input string nm);
      chk({nm, "_out_valid"}, out_valid, 0);
      chk({nm, "_out"}, out, 0);
      chk({nm, "_carry"}, carry, 0);
      chk({nm, "_ovf"}, ovf, 0);
      chk({nm, "_txn_cnt"}, txn_cnt, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      rstn = 1'b0; in_valid = 1'b0; op = '0; inA = '0; inB = '0;
      #3;
      reset_check("rst0");
      repeat (3) @(posedge clk);
      #3 rstn = 1'b1;
      @(posedge clk); #1;
      chk("rst0_in_ready", in_ready, 1);

      // Basic ops with downstream always ready.
      drive_beat(2'd0, 8'h7F, 8'h01);
      drive_beat(2'd1, 8'h05, 8'h07);
      drive_beat(2'd2, 8'h10, 8'hF0);
      drive_beat(2'd3, 8'h10, 8'hF0);
      drain();

      // Wrap / boundary cases.
      drive_beat(2'd0, 8'hFF, 8'h01);
      drive_beat(2'd1, 8'h00, 8'h01);
      drive_beat(2'd1, 8'h80, 8'h01);
      drive_beat(2'd0, 8'h80, 8'h80);
      drive_beat(2'd2, 8'hFF, 8'hFF);
      drain();

      // 100 back-to-back random beats.
      base = txn_model;
      for (int i = 0; i < 100; i++) begin
         drive_beat(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
      end
      drain();
      chk("txn_after_100", txn_cnt, (base + 100) % (1 << CW));

      // Backpressure: downstream stalls for 5 cycles while input stays valid.
      rdy_mode = 2;
      @(posedge clk); #1;
      ro = 2'($urandom_range(0, 3)); ra = W'($urandom); rb = W'($urandom);
      for (int i = 0; i < 5; i++) begin
         op = ro; inA = ra; inB = rb; in_valid = 1'b1;
         #5;
         if (in_ready) begin
            exp_t e;
            ref_op(ro, ra, rb, e.r, e.c, e.v);
            e.t = cyc;
            q.push_back(e);
            ro = 2'($urandom_range(0, 3)); ra = W'($urandom); rb = W'($urandom);
         end
         @(posedge clk); #1;
      end
      op = ro; inA = ra; inB = rb;
      #5;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_held_beats", q.size(), S);
      @(posedge clk); #1;
      in_valid = 1'b0;
      rdy_mode = 0;
      drain();

      // Random backpressure with random input gaps.
      rdy_mode = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         drive_beat(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
      end
      rdy_mode = 0;
      drain();

      // Reset with two beats in flight.
      drive_beat(2'd0, 8'h12, 8'h34);
      drive_beat(2'd1, 8'h40, 8'h03);
      #2 rstn = 1'b0;
      #1;
      reset_check("rst_mid");
      q.delete();
      txn_model = 0;
      repeat (2) @(posedge clk);
      #3 rstn = 1'b1;
      #1;
      chk("rst_mid_in_ready", in_ready, 1);
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         drive_beat(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
